// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types and defaults for the unified IF/DM memory arbiter.
// The optional statistics counters are enabled with the MEM_ARB_STATS_EN macro.
package unified_mem_arbiter_pkg;

    localparam int ADDR_WIDTH_DEF = 8;
    localparam int DATA_WIDTH_DEF = 16;
    localparam int WAIT_CNT_WIDTH = 4;

    typedef enum logic {
        DM_PRIO    = 1'b0,
        IF_STARVED = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic valid;
        logic is_dm;
    } owner_tag_t;

    // Saturating increment used by the IF starvation counter.
    function automatic logic [WAIT_CNT_WIDTH-1:0] sat_inc(
        input logic [WAIT_CNT_WIDTH-1:0] cnt,
        input logic [WAIT_CNT_WIDTH-1:0] limit
    );
        return (cnt < limit) ? cnt + 1'b1 : cnt;
    endfunction

endpackage

// File: rtl/unified_mem_arbiter_rd_owner_pipe.sv
// Shift register carrying {valid, is_dm} owner tags alongside the memory read latency.
module rd_owner_pipe
    import unified_mem_arbiter_pkg::*;
#(
    parameter int RD_LATENCY = 1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  owner_tag_t tag_in,
    output owner_tag_t tag_out,
    output logic       busy_o
);

    owner_tag_t stage [RD_LATENCY];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= tag_in;
            for (int i = 1; i < RD_LATENCY; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    always_comb begin
        busy_o = 1'b0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            busy_o = busy_o | stage[i].valid;
        end
    end

    assign tag_out = stage[RD_LATENCY-1];

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates a single-port synchronous-read memory between IF and DM with DM priority
// and a starvation escape for IF. Define MEM_ARB_STATS_EN to add the statistics counters.
module unified_mem_arbiter
    import unified_mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int RD_LATENCY = 1,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  if_req_i,
    input  logic [ADDR_WIDTH-1:0] if_addr_i,
    output logic                  if_gnt_o,
    output logic                  if_rvalid_o,
    output logic [DATA_WIDTH-1:0] if_rdata_o,
    output logic                  if_stall_o,
    input  logic                  dm_req_i,
    input  logic                  dm_we_i,
    input  logic [ADDR_WIDTH-1:0] dm_addr_i,
    input  logic [DATA_WIDTH-1:0] dm_wdata_i,
    output logic                  dm_gnt_o,
    output logic                  dm_rvalid_o,
    output logic [DATA_WIDTH-1:0] dm_rdata_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  mem_rd_o,
    output logic                  mem_wr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  busy_o
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [15:0]           stat_conflict_o,
    output logic [15:0]           stat_force_o
`endif
);

    localparam logic [WAIT_CNT_WIDTH-1:0] MAX_WAIT_C = WAIT_CNT_WIDTH'(MAX_WAIT);

    arb_state_e                state;
    logic [WAIT_CNT_WIDTH-1:0] wait_cnt;
    logic [WAIT_CNT_WIDTH-1:0] wait_cnt_nxt;
    logic                      if_gnt;
    logic                      dm_gnt;
    owner_tag_t                tag_in;
    owner_tag_t                tag_out;
    logic [DATA_WIDTH-1:0]     if_rdata_q;
    logic [DATA_WIDTH-1:0]     dm_rdata_q;

    // A starved IF wins over DM; otherwise DM has fixed priority. No grant while in reset.
    always_comb begin
        if_gnt = 1'b0;
        dm_gnt = 1'b0;
        if (rst_i) begin
            if (state == IF_STARVED && if_req_i) begin
                if_gnt = 1'b1;
            end else if (dm_req_i) begin
                dm_gnt = 1'b1;
            end else if (if_req_i) begin
                if_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        wait_cnt_nxt = '0;
        if (if_req_i && !if_gnt) begin
            wait_cnt_nxt = sat_inc(wait_cnt, MAX_WAIT_C);
        end
    end

    // Leaving IF_STARVED without a grant only happens if IF withdraws its request.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state    <= DM_PRIO;
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt_nxt;
            case (state)
                DM_PRIO: begin
                    if (wait_cnt_nxt == MAX_WAIT_C) begin
                        state <= IF_STARVED;
                    end
                end
                IF_STARVED: begin
                    if (if_gnt || !if_req_i) begin
                        state <= DM_PRIO;
                    end
                end
                default: state <= DM_PRIO;
            endcase
        end
    end

    always_comb begin
        mem_addr_o  = '0;
        mem_rd_o    = 1'b0;
        mem_wr_o    = 1'b0;
        mem_wdata_o = '0;
        if (dm_gnt) begin
            mem_addr_o  = dm_addr_i;
            mem_rd_o    = ~dm_we_i;
            mem_wr_o    = dm_we_i;
            mem_wdata_o = dm_wdata_i;
        end else if (if_gnt) begin
            mem_addr_o = if_addr_i;
            mem_rd_o   = 1'b1;
        end
    end

    assign if_gnt_o   = if_gnt;
    assign dm_gnt_o   = dm_gnt;
    assign if_stall_o = rst_i & if_req_i & ~if_gnt;

    assign tag_in.valid = mem_rd_o;
    assign tag_in.is_dm = dm_gnt;

    rd_owner_pipe #(
        .RD_LATENCY(RD_LATENCY)
    ) u_rd_owner_pipe (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .tag_in (tag_in),
        .tag_out(tag_out),
        .busy_o (busy_o)
    );

    assign if_rvalid_o = tag_out.valid & ~tag_out.is_dm;
    assign dm_rvalid_o = tag_out.valid & tag_out.is_dm;

    // Returned data is forwarded in the rvalid cycle and held afterwards.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            if (if_rvalid_o) begin
                if_rdata_q <= mem_rdata_i;
            end
            if (dm_rvalid_o) begin
                dm_rdata_q <= mem_rdata_i;
            end
        end
    end

    assign if_rdata_o = if_rvalid_o ? mem_rdata_i : if_rdata_q;
    assign dm_rdata_o = dm_rvalid_o ? mem_rdata_i : dm_rdata_q;

`ifdef MEM_ARB_STATS_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stat_conflict_o <= '0;
            stat_force_o    <= '0;
        end else begin
            if (if_req_i && dm_req_i && stat_conflict_o != 16'hFFFF) begin
                stat_conflict_o <= stat_conflict_o + 16'd1;
            end
            if (if_gnt && state == IF_STARVED && stat_force_o != 16'hFFFF) begin
                stat_force_o <= stat_force_o + 16'd1;
            end
        end
    end
`endif

endmodule
